// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory line arbiter.
// Optional feature: MEM_ARB_RR_EN selects round-robin arbitration
// (fixed priority with D winning ties otherwise).
package mem_arb_pkg;

  // Byte offset bits within a 32-byte cache line.
  localparam int LINE_OFS_W = 5;

  // Encoding of the 1-bit "last winner" register used by round-robin.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    I    = 2'd1,
    D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the I-side and D-side line requests.
// With MEM_ARB_RR_EN defined, a 1-bit last_q register remembers the
// previous winner and a tie goes to the other side (first tie goes to I).
// Without it, D always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic update,
`endif
  input  logic i_req,
  input  logic d_req,
  output logic pick_d
);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Remember which side won the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_D;
    end else if (update) begin
      last_q <= pick_d ? LAST_D : LAST_I;
    end
  end

  // D wins when it is alone, or on a tie when I won last time.
  always_comb begin
    pick_d = d_req && (!i_req || (last_q == LAST_I));
  end
`else
  // D wins whenever it requests; I only wins when D is quiet.
  always_comb begin
    pick_d = d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory line port between the I-cache miss path
// and the D-cache fill/write-back path, one 256-bit line at a time.
// Optional feature: MEM_ARB_RR_EN (round-robin instead of D-priority).
//
// Handshake: requesters hold req until their 1-cycle ready pulse; memory
// sees mem_req held (with stable we/addr/wdata) until it returns a
// 1-cycle mem_ready_in, whose mem_rdata_in is captured that same cycle.
// A dead DONE cycle after every completion keeps a not-yet-dropped req
// from being granted twice.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_in,
  input  logic [ADDR_W-1:0] i_addr_in,
  output logic [LINE_W-1:0] i_rdata_out,
  output logic              i_ready_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [LINE_W-1:0] d_wdata_in,
  output logic [LINE_W-1:0] d_rdata_out,
  output logic              d_ready_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [LINE_W-1:0] mem_wdata_out,
  input  logic [LINE_W-1:0] mem_rdata_in,
  input  logic              mem_ready_in,
  output state_e            state_dbg
);

  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << LINE_OFS_W) - 1);

  state_e            state_q;
  state_e            state_d;
  owner_e            owner_q;
  logic              grant;
  logic              complete;
  logic              pick_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .update (grant),
`endif
    .i_req  (i_req_in),
    .d_req  (d_req_in),
    .pick_d (pick_d)
  );

  // Address of whichever side is about to win.
  always_comb begin
    sel_addr = pick_d ? d_addr_in : i_addr_in;
  end

  // Next-state: grant from IDLE, finish on mem_ready in BUSY, one dead cycle.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_in || d_req_in) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready_in) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request; held unchanged for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= pick_d ? D : I;
      we_q    <= pick_d && d_we_in;
      addr_q  <= sel_addr & ~OFS_MASK;
      wdata_q <= pick_d ? d_wdata_in : '0;
    end else if (state_q == DONE) begin
      owner_q <= NONE;
    end
  end

  // Route the returned line and a 1-cycle ready pulse to the owner only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ready_q <= complete && (owner_q == I);
      d_ready_q <= complete && (owner_q == D);
      if (complete && (owner_q == I)) begin
        i_rdata_q <= mem_rdata_in;
      end
      if (complete && (owner_q == D)) begin
        d_rdata_q <= mem_rdata_in;
      end
    end
  end

  assign mem_req_out   = (state_q == BUSY);
  assign mem_we_out    = we_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign i_rdata_out   = i_rdata_q;
  assign d_rdata_out   = d_rdata_q;
  assign i_ready_out   = i_ready_q;
  assign d_ready_out   = d_ready_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transactions with a
// protocol-level reference model and a per-cycle compare process.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i_req_in = 1'b0;
  logic [ADDR_W-1:0] i_addr_in = '0;
  logic [LINE_W-1:0] i_rdata_out;
  logic              i_ready_out;
  logic              d_req_in = 1'b0;
  logic              d_we_in = 1'b0;
  logic [ADDR_W-1:0] d_addr_in = '0;
  logic [LINE_W-1:0] d_wdata_in = '0;
  logic [LINE_W-1:0] d_rdata_out;
  logic              d_ready_out;
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [LINE_W-1:0] mem_wdata_out;
  logic [LINE_W-1:0] mem_rdata_in = '0;
  logic              mem_ready_in = 1'b0;
  state_e            state_dbg;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_in      (i_req_in),
    .i_addr_in     (i_addr_in),
    .i_rdata_out   (i_rdata_out),
    .i_ready_out   (i_ready_out),
    .d_req_in      (d_req_in),
    .d_we_in       (d_we_in),
    .d_addr_in     (d_addr_in),
    .d_wdata_in    (d_wdata_in),
    .d_rdata_out   (d_rdata_out),
    .d_ready_out   (d_ready_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .mem_ready_in  (mem_ready_in),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic              is_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of what the arbiter has promised so far.
  txn_t              cur;
  bit                in_txn = 1'b0;
  bit                resp_pending = 1'b0;
  logic [LINE_W-1:0] resp_data;
  logic [LINE_W-1:0] mdl_i_rdata = '0;
  logic [LINE_W-1:0] mdl_d_rdata = '0;
  int                since_ready = 100;

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_mem_req", mem_req_out, 0);
      check("rst_mem_we", mem_we_out, 0);
      check("rst_mem_addr", mem_addr_out, 0);
      check("rst_mem_wdata", mem_wdata_out, 0);
      check("rst_i_ready", i_ready_out, 0);
      check("rst_d_ready", d_ready_out, 0);
      check("rst_i_rdata", i_rdata_out, 0);
      check("rst_d_rdata", d_rdata_out, 0);
      check("rst_state", state_dbg, IDLE);
      in_txn       = 1'b0;
      resp_pending = 1'b0;
      mdl_i_rdata  = '0;
      mdl_d_rdata  = '0;
      since_ready  = 100;
    end else begin
      if (resp_pending) begin
        check("done_mem_req_low", mem_req_out, 0);
        check("owner_i_ready", i_ready_out, !cur.is_d);
        check("owner_d_ready", d_ready_out, cur.is_d);
        if (cur.is_d) mdl_d_rdata = resp_data;
        else          mdl_i_rdata = resp_data;
        resp_pending = 1'b0;
        in_txn       = 1'b0;
        since_ready  = 0;
      end else begin
        check("no_i_ready", i_ready_out, 0);
        check("no_d_ready", d_ready_out, 0);
        if (since_ready < 100) since_ready++;
      end
      check("i_rdata", i_rdata_out, mdl_i_rdata);
      check("d_rdata", d_rdata_out, mdl_d_rdata);
      if (mem_req_out) begin
        if (!in_txn) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_mem_req: got mem_req=1 expected no request at %0t", $time);
          end else begin
            cur    = exp_q.pop_front();
            in_txn = 1'b1;
            check("grant_gap_ok", (since_ready >= 2), 1);
          end
        end
        if (in_txn) begin
          check("mem_addr", mem_addr_out, cur.addr);
          check("mem_we", mem_we_out, cur.we);
          if (cur.we) check("mem_wdata", mem_wdata_out, cur.wdata);
          if (mem_ready_in) begin
            resp_pending = 1'b1;
            resp_data    = mem_rdata_in;
          end
        end
      end else if (in_txn) begin
        check("mem_req_held", mem_req_out, 1);
        in_txn = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit mem_en = 1'b1;
  int mem_lat = 2;
  int mem_cnt = 0;
  bit i_drop_pend = 1'b0;
  bit d_drop_pend = 1'b0;

  // One clock: memory responder and requesters react just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_ready_in) begin
      mem_ready_in = 1'b0;
      mem_cnt      = 0;
    end else if (mem_en && mem_req_out) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_ready_in = 1'b1;
        mem_rdata_in = cur.rdata;
      end
    end
    if (i_drop_pend) begin i_req_in = 1'b0; i_drop_pend = 1'b0; end
    if (d_drop_pend) begin d_req_in = 1'b0; d_drop_pend = 1'b0; end
    if (i_ready_out) i_drop_pend = 1'b1;
    if (d_ready_out) d_drop_pend = 1'b1;
  endtask

  task automatic req_i(input logic [ADDR_W-1:0] a);
    i_addr_in = a;
    i_req_in  = 1'b1;
  endtask

  task automatic req_d(input logic we, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] wd);
    d_we_in    = we;
    d_addr_in  = a;
    d_wdata_in = wd;
    d_req_in   = 1'b1;
  endtask

  task automatic expect_txn(input logic is_d, input logic we,
                            input logic [ADDR_W-1:0] raw_addr,
                            input logic [LINE_W-1:0] wd,
                            input logic [LINE_W-1:0] rd);
    txn_t t;
    t.is_d  = is_d;
    t.we    = we;
    t.addr  = raw_addr & 32'hFFFF_FFE0;
    t.wdata = wd;
    t.rdata = rd;
    exp_q.push_back(t);
  endtask

  // Run until every expected transaction has completed, bounded.
  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_txn || resp_pending || i_req_in || d_req_in)
           && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL wait_done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      i_req_in = 1'b0;
      d_req_in = 1'b0;
    end
    repeat (4) step();
  endtask

  function automatic logic [LINE_W-1:0] fill(input logic [31:0] w);
    return {8{w}};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    logic [LINE_W-1:0] data_a5;
    logic [LINE_W-1:0] data_11;
    data_a5 = {32{8'hA5}};
    data_11 = {32{8'h11}};

    repeat (2) step();
    rst_n = 1'b1;
    step();

    // 1. I-only fill, memory answers on the 4th BUSY cycle.
    mem_lat = 4;
    expect_txn(1'b0, 1'b0, 32'h0000_1234, '0, data_a5);
    req_i(32'h0000_1234);
    step();
    check("t1_req_latency", mem_req_out, 1);
    check("t1_addr_literal", mem_addr_out, 32'h0000_1220);
    check("t1_we_literal", mem_we_out, 0);
    wait_done(50);
    check("t1_i_rdata_literal", i_rdata_out, data_a5);
    check("t1_d_rdata_untouched", d_rdata_out, 0);

    // 2. D write-back.
    mem_lat = 3;
    expect_txn(1'b1, 1'b1, 32'h8000_0040, data_11, fill(32'hDEAD_BEEF));
    req_d(1'b1, 32'h8000_0040, data_11);
    step();
    check("t2_we_literal", mem_we_out, 1);
    check("t2_wdata_literal", mem_wdata_out, data_11);
    check("t2_addr_literal", mem_addr_out, 32'h8000_0040);
    wait_done(50);
    check("t2_d_rdata_literal", d_rdata_out, fill(32'hDEAD_BEEF));
    check("t2_i_rdata_holds", i_rdata_out, data_a5);

    // 3. Simultaneous held requests, two rounds.
    for (int r = 0; r < 2; r++) begin
      logic [ADDR_W-1:0] ia;
      logic [ADDR_W-1:0] da;
      logic [LINE_W-1:0] ird;
      logic [LINE_W-1:0] drd;
      ia  = 32'h0000_2008 + 32'(r * 32'h100);
      da  = 32'h0000_3011 + 32'(r * 32'h100);
      ird = fill(32'h1000_0000 + 32'(r));
      drd = fill(32'h2000_0000 + 32'(r));
      mem_lat = 2 + r;
`ifdef MEM_ARB_RR_EN
      expect_txn(1'b0, 1'b0, ia, '0, ird);
      expect_txn(1'b1, 1'b0, da, '0, drd);
`else
      expect_txn(1'b1, 1'b0, da, '0, drd);
      expect_txn(1'b0, 1'b0, ia, '0, ird);
`endif
      req_i(ia);
      req_d(1'b0, da, '0);
      step();
`ifdef MEM_ARB_RR_EN
      check("t3_first_addr_literal", mem_addr_out, ia & 32'hFFFF_FFE0);
`else
      check("t3_first_addr_literal", mem_addr_out, da & 32'hFFFF_FFE0);
`endif
      wait_done(80);
      check("t3_i_rdata", i_rdata_out, ird);
      check("t3_d_rdata", d_rdata_out, drd);
    end

    // 4. Stale req: held through the ready cycle, must not be re-granted.
    mem_lat = 2;
    expect_txn(1'b0, 1'b0, 32'h0000_0ABC, '0, fill(32'h0BAD_CAFE));
    req_i(32'h0000_0ABC);
    while (!i_ready_out && mem_cnt < 20) step();
    check("t4_ready_seen", i_ready_out, 1);
    step();
    check("t4_no_regrant", mem_req_out, 0);
    step();
    check("t4_still_idle", mem_req_out, 0);
    wait_done(20);

    // 5. Spurious mem_ready while IDLE.
    mem_en       = 1'b0;
    mem_rdata_in = fill(32'hFFFF_0000);
    mem_ready_in = 1'b1;
    step();
    step();
    check("t5_state_idle", state_dbg, IDLE);
    check("t5_no_i_ready", i_ready_out, 0);
    check("t5_no_d_ready", d_ready_out, 0);
    mem_en = 1'b1;

    // 6. Reset in BUSY, late mem_ready ignored, then a clean grant.
    mem_lat = 20;
    expect_txn(1'b0, 1'b0, 32'h0000_4444, '0, fill(32'h4444_4444));
    req_i(32'h0000_4444);
    repeat (3) step();
    check("t6_busy_before_rst", mem_req_out, 1);
    rst_n       = 1'b0;
    i_req_in    = 1'b0;
    i_drop_pend = 1'b0;
    mem_en      = 1'b0;
    mem_cnt     = 0;
    exp_q.delete();
    #1;
    check("t6_rst_mem_req", mem_req_out, 0);
    check("t6_rst_addr", mem_addr_out, 0);
    check("t6_rst_i_rdata", i_rdata_out, 0);
    check("t6_rst_d_rdata", d_rdata_out, 0);
    step();
    rst_n = 1'b1;
    step();
    mem_rdata_in = fill(32'h7777_7777);
    mem_ready_in = 1'b1;
    step();
    step();
    check("t6_late_ready_ignored", state_dbg, IDLE);
    mem_en  = 1'b1;
    mem_lat = $urandom_range(2, 5);
    expect_txn(1'b0, 1'b0, 32'h0000_551F, '0, fill(32'h5500_0055));
    req_i(32'h0000_551F);
    step();
    check("t6_regrant_addr", mem_addr_out, 32'h0000_5500);
    wait_done(50);
    check("t6_i_rdata_literal", i_rdata_out, fill(32'h5500_0055));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
